// File: rtl/quad_input_filter.sv
// quad_input_filter
// Input conditioning for a quadrature encoder ahead of the quad decoder:
// a two-flop synchroniser per channel, a consecutive-sample glitch filter
// per channel, and classification of each filtered transition as legal
// (one channel moved) or illegal (both moved on the same edge), with a
// saturating diagnostic count of illegal transitions.
module quad_input_filter #(
    parameter int FILT_LEN = 2,  // clocks a synced input must disagree before the output follows (1..255)
    parameter int ERR_W    = 8   // width of the saturating illegal-transition counter
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             quadA_in,
    input  logic             quadB_in,
    input  logic             err_clr,
    output logic             quadA,
    output logic             quadB,
    output logic             edge_stb,
    output logic             err_stb,
    output logic [ERR_W-1:0] err_count
);

    localparam int               CNT_W    = $clog2(FILT_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    logic [1:0]       sync_a;
    logic [1:0]       sync_b;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    logic             flip_a;
    logic             flip_b;

    // An output flips on the FILT_LEN-th consecutive disagreeing sample.
    always_comb begin
        flip_a = (sync_a[1] != quadA) && (cnt_a == CNT_LAST);
        flip_b = (sync_b[1] != quadB) && (cnt_b == CNT_LAST);
    end

    // Two-flop synchroniser for the asynchronous encoder pins.
    // NOTE: every clocked block uses non-blocking assignments so that all
    // flops sample the pre-edge values; blocking here would collapse the
    // two synchroniser stages into one.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= 2'b00;
            sync_b <= 2'b00;
        end else begin
            sync_a <= {sync_a[0], quadA_in};
            sync_b <= {sync_b[0], quadB_in};
        end
    end

    // Channel A glitch filter: count disagreeing samples, follow on the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_a <= '0;
            quadA <= 1'b0;
        end else if (sync_a[1] == quadA) begin
            cnt_a <= '0;
        end else if (flip_a) begin
            quadA <= sync_a[1];
            cnt_a <= '0;
        end else begin
            cnt_a <= cnt_a + 1'b1;
        end
    end

    // Channel B glitch filter, independent of channel A.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_b <= '0;
            quadB <= 1'b0;
        end else if (sync_b[1] == quadB) begin
            cnt_b <= '0;
        end else if (flip_b) begin
            quadB <= sync_b[1];
            cnt_b <= '0;
        end else begin
            cnt_b <= cnt_b + 1'b1;
        end
    end

    // Classify the transition registered on this edge: one channel is a legal
    // Gray-code step, both channels together is an illegal jump.
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_stb <= 1'b0;
            err_stb  <= 1'b0;
        end else begin
            edge_stb <= flip_a ^ flip_b;
            err_stb  <= flip_a & flip_b;
        end
    end

    // Saturating illegal-transition counter; counts on the same edge err_stb
    // is raised, and a clear request beats a simultaneous increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= '0;
        end else if (flip_a && flip_b && (err_count != ERR_MAX)) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_quad_input_filter.sv
// tb_quad_input_filter
// Scoreboard bench: the stimulus process drives inputs on the falling edge and
// runs a window-based reference model that predicts every output transition;
// predicted transitions go into a queue that an independent monitor drains
// whenever the DUT raises edge_stb or err_stb.
module tb_quad_input_filter;

    localparam int FILT_LEN = 2;
    localparam int ERR_W    = 2;
    localparam int ERR_MAX  = (1 << ERR_W) - 1;

    logic             clk;
    logic             rst;
    logic             quadA_in;
    logic             quadB_in;
    logic             err_clr;
    logic             quadA;
    logic             quadB;
    logic             edge_stb;
    logic             err_stb;
    logic [ERR_W-1:0] err_count;

    quad_input_filter #(
        .FILT_LEN(FILT_LEN),
        .ERR_W   (ERR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .quadA_in (quadA_in),
        .quadB_in (quadB_in),
        .err_clr  (err_clr),
        .quadA    (quadA),
        .quadB    (quadB),
        .edge_stb (edge_stb),
        .err_stb  (err_stb),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising-edge counter used to timestamp predicted transitions.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int stamp;
        bit is_err;
        bit qa;
        bit qb;
        int cnt;
    } ev_t;

    ev_t exp_q[$];

    // Reference model state: raw and synced sample histories since last reset.
    bit raw_a[$];
    bit raw_b[$];
    bit syn_a[$];
    bit syn_b[$];
    bit m_qa   = 1'b0;
    bit m_qb   = 1'b0;
    bit m_edge = 1'b0;
    bit m_err  = 1'b0;
    int m_cnt  = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    endtask

    // Value leaving the second synchroniser stage: the pin sampled two edges back.
    function automatic bit delayed2(input bit q[$]);
        if (q.size() < 2) return 1'b0;
        return q[q.size() - 2];
    endfunction

    // True when the last FILT_LEN synced samples all disagree with the output.
    function automatic bit window_differs(input bit q[$], input bit cur);
        if (q.size() < FILT_LEN) return 1'b0;
        for (int i = q.size() - FILT_LEN; i < q.size(); i++)
            if (q[i] == cur) return 1'b0;
        return 1'b1;
    endfunction

    // One clock of stimulus plus the model's prediction for the next rising edge.
    task automatic drive(input bit a, input bit b, input bit r, input bit clr);
        bit sa, sb, fa, fb;
        @(negedge clk);
        quadA_in = a;
        quadB_in = b;
        rst      = r;
        err_clr  = clr;
        if (r) begin
            raw_a.delete(); raw_b.delete(); syn_a.delete(); syn_b.delete();
            m_qa = 0; m_qb = 0; m_cnt = 0; m_edge = 0; m_err = 0;
        end else begin
            sa = delayed2(raw_a);
            sb = delayed2(raw_b);
            raw_a.push_back(a);
            raw_b.push_back(b);
            syn_a.push_back(sa);
            syn_b.push_back(sb);
            if (raw_a.size() > 4) begin void'(raw_a.pop_front()); void'(raw_b.pop_front()); end
            if (syn_a.size() > FILT_LEN + 2) begin void'(syn_a.pop_front()); void'(syn_b.pop_front()); end
            fa = window_differs(syn_a, m_qa);
            fb = window_differs(syn_b, m_qb);
            if (fa) m_qa = ~m_qa;
            if (fb) m_qb = ~m_qb;
            if (clr) m_cnt = 0;
            else if (fa && fb && m_cnt < ERR_MAX) m_cnt++;
            m_edge = fa ^ fb;
            m_err  = fa & fb;
            if (fa || fb) exp_q.push_back('{cyc + 1, fa & fb, m_qa, m_qb, m_cnt});
        end
    endtask

    task automatic hold(input bit a, input bit b, input int n);
        for (int i = 0; i < n; i++) drive(a, b, 1'b0, 1'b0);
    endtask

    // Compare the full output state just after the next rising edge.
    task automatic check_state(input string name);
        @(posedge clk);
        #1;
        check({name, ".quadA"},     int'(quadA),     int'(m_qa));
        check({name, ".quadB"},     int'(quadB),     int'(m_qb));
        check({name, ".edge_stb"},  int'(edge_stb),  int'(m_edge));
        check({name, ".err_stb"},   int'(err_stb),   int'(m_err));
        check({name, ".err_count"}, int'(err_count), m_cnt);
    endtask

    // Monitor: every DUT strobe must match the oldest predicted transition.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (edge_stb || err_stb) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_event: edge_stb=%0b err_stb=%0b at cycle %0d, none predicted",
                             edge_stb, err_stb, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("ev_cycle",     cyc,             e.stamp);
                    check("ev_err_stb",   int'(err_stb),   int'(e.is_err));
                    check("ev_edge_stb",  int'(edge_stb),  int'(!e.is_err));
                    check("ev_quadA",     int'(quadA),     int'(e.qa));
                    check("ev_quadB",     int'(quadB),     int'(e.qb));
                    check("ev_err_count", int'(err_count), e.cnt);
                end
            end
        end
    end

    initial begin
        bit a, b, r, c;
        int len;
        rst      = 1'b1;
        quadA_in = 1'b1;
        quadB_in = 1'b1;
        err_clr  = 1'b0;

        // Reset with inputs high: everything held at zero.
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b1, 1'b0);
        check_state("reset");
        check("reset_quadA_const", int'(quadA), 0);
        check("reset_count_const", int'(err_count), 0);

        // Release: both channels qualify together -> one illegal transition.
        hold(1'b1, 1'b1, 2 + FILT_LEN + 3);
        check_state("release");
        check("release_count_const", int'(err_count), 1);

        // Return to 00 legally, then a full CW cycle held 3 clk per state.
        hold(1'b0, 1'b1, 6);
        hold(1'b0, 1'b0, 6);
        hold(1'b1, 1'b0, 3);
        hold(1'b1, 1'b1, 3);
        hold(1'b0, 1'b1, 3);
        hold(1'b0, 1'b0, 6);
        check_state("cw_cycle");

        // Glitches: one clock, and FILT_LEN-1 clocks, must never reach quadA.
        hold(1'b1, 1'b0, 1);
        hold(1'b0, 1'b0, 6);
        hold(1'b1, 1'b0, FILT_LEN - 1);
        hold(1'b0, 1'b0, 6);
        check_state("glitch");
        check("glitch_quadA_const", int'(quadA), 0);

        // Both pins rise on the same clock.
        hold(1'b1, 1'b1, 6);
        check_state("double_step");

        // Five more illegal steps saturate the 2-bit counter.
        for (int i = 0; i < 5; i++) begin
            a = (i % 2 == 0) ? 1'b0 : 1'b1;
            hold(a, a, 6);
        end
        check_state("saturate");
        check("saturate_const", int'(err_count), ERR_MAX);

        // Sixth illegal step with err_clr on the very edge it is registered.
        hold(1'b1, 1'b1, 1 + FILT_LEN);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        hold(1'b1, 1'b1, 3);
        check_state("clr_wins");
        check("clr_wins_const", int'(err_count), 0);

        // Reset while channel A is mid-qualification, then re-qualify.
        hold(1'b0, 1'b1, 6);
        hold(1'b1, 1'b1, 3);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        check_state("mid_reset");
        hold(1'b1, 1'b1, 1 + FILT_LEN);
        check_state("requalify_early");
        hold(1'b1, 1'b1, 1);
        check_state("requalify");
        check("requalify_quadA_const", int'(quadA), 1);

        // Randomised traffic with occasional clears and resets.
        for (int i = 0; i < 1500; i++) begin
            a   = 1'($urandom_range(0, 1));
            b   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 4);
            for (int j = 0; j < len; j++) begin
                r = ($urandom_range(0, 99) == 0);
                c = ($urandom_range(0, 15) == 0);
                drive(a, b, r, c);
            end
        end
        hold(quadA_in, quadB_in, 10);
        check_state("random_end");

        // Any prediction left over is a transition the DUT never produced.
        while (exp_q.size() > 0) begin
            ev_t e;
            e = exp_q.pop_front();
            n_checks++;
            $display("FAIL missing_event: predicted at cycle %0d (err=%0b) never seen", e.stamp, e.is_err);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
